sdram_cmd_sched: RTL
====================

SDRAM_CMD_SCHED -- requirements
Module: sdram_cmd_sched

Interface
REQ-001 SHALL have parameter ROW_WD, 13, SDRAM row address width.
REQ-002 SHALL have parameter COL_WD, 10, column address width.
REQ-003 SHALL have parameter LEN_WD, 12, burst length field width.
REQ-004 SHALL have parameter IDLE_CLOSE, 64, idle cycles before an open row is precharged (>=2).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  2  per-requester request valid.
REQ-008 req_ready  out  2  per-requester accept, one-hot, one-cycle pulse.
REQ-009 req_wr  in  2  per-requester direction: 1 write, 0 read.
REQ-010 req_row  in  2*ROW_WD  row address; requester n at [n*ROW_WD +: ROW_WD].
REQ-011 req_col  in  2*COL_WD  column address, same packing.
REQ-012 req_ba  in  4  bank address, 2 bits per requester.
REQ-013 req_len  in  2*LEN_WD  full-page burst length, same packing.
REQ-014 done  out  2  per-requester completion pulse.
REQ-015 cmd_valid  out  1  command valid to the SDRAM controller.
REQ-016 cmd_ready  in  1  controller accepts command; fire = cmd_valid & cmd_ready.
REQ-017 cmd  out  4  command code (PRECHARGE=2, ACTIVE=5, READ=6, WRITE=7).
REQ-018 row_addr  out  ROW_WD  row / A10 field; col_addr out COL_WD; cmd_ba out 2.
REQ-019 r_cmd_len  out  LEN_WD  read length; w_cmd_len out LEN_WD write length.

Function
REQ-020 SHALL implement states IDLE, PRE, ACT, RW; only IDLE asserts req_ready; PRE/ACT/RW assert cmd_valid.
REQ-021 In IDLE with any req_valid, SHALL grant one requester round-robin: both valid -> requester other than last granted; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-022 On grant SHALL pulse req_ready[g] that cycle and latch g, wr, row, col, ba, len.
REQ-023 Next state from grant: open row, same bank and row -> RW; open row, miss -> PRE; no open row -> ACT.
REQ-024 cmd_valid SHALL rise the cycle after grant; cmd and all address/length outputs SHALL stay stable until fire.
REQ-025 PRE: cmd=2, cmd_ba=open bank, row_addr all zero (A10=0, single bank); on fire clear open flag; then ACT if request latched, else IDLE.
REQ-026 ACT: cmd=5, row_addr=latched row, cmd_ba=latched bank; on fire set open flag, record open bank/row; then RW.
REQ-027 RW: cmd=6 read / 7 write, col_addr=latched col, row_addr all zero (A10=0, no auto-precharge), cmd_ba=latched bank; length on r_cmd_len (read) or w_cmd_len (write), the other zero.
REQ-028 On RW fire SHALL go IDLE and pulse done[g] the following cycle.
REQ-029 Outside RW, r_cmd_len and w_cmd_len SHALL be zero; in IDLE, cmd, row_addr, col_addr, cmd_ba SHALL be zero.
REQ-030 Idle counter: in IDLE with open row and no req_valid, SHALL increment; when it reaches IDLE_CLOSE-1, go PRE with no latched request; cleared on any grant or leaving IDLE.
REQ-031 req_valid in the cycle the idle counter hits IDLE_CLOSE-1 SHALL win: grant, no timeout precharge.
REQ-032 cmd_ready low for any number of cycles SHALL hold state; no timeout on downstream stall.
REQ-033 req_valid dropped before grant SHALL be ignored; no request is queued.

Reset
REQ-034 Reset SHALL force IDLE, req_ready=0, done=0, cmd_valid=0, cmd/row_addr/col_addr/cmd_ba/lengths=0, open flag=0, idle counter=0, pointer=1.
REQ-035 Reset mid-sequence SHALL abandon the request without done; open flag cleared.

Structure
REQ-036 Package sdram_pkg SHALL hold command-code constants and the state enumeration.
REQ-037 SHALL instantiate one sub-module rr_arb2 (2-way round-robin, grant pointer update on accept).

Verification
REQ-038 Req0 read row 0x12 bank 1 col 0x20 len 8, cmd_ready=1, no open row -> ACT(row 0x12, ba 1), READ(col 0x20, r_cmd_len 8), done[0]; no PRE.
REQ-039 Next req1 write same bank/row col 0x40 -> WRITE directly (row hit), w_cmd_len=len, done[1].
REQ-040 Req0 row 0x13 bank 1 while row 0x12 open -> PRE(ba 1, A10=0), ACT(0x13), READ.
REQ-041 Both valid together twice -> grants 0, 1, 0 alternate; cmd_ready low 5 cycles -> outputs stable, fire on sixth.
REQ-042 Row open, no requests, IDLE_CLOSE=64 -> PRE issued 64 cycles after entering IDLE; req on 63rd idle cycle -> grant instead.
REQ-043 rst_n low during ACT stall -> all outputs zero same cycle, no done, next request starts with ACT.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command codes and scheduler state encoding
package sdram_pkg;
  localparam logic [3:0] CMD_PRE = 4'd2;
  localparam logic [3:0] CMD_ACT = 4'd5;
  localparam logic [3:0] CMD_RD = 4'd6;
  localparam logic [3:0] CMD_WR = 4'd7;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACT, S_RW} state_t;
endpackage

// File: rtl/sdram_cmd_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, pointer advances only on accept
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last;
  assign gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
  // remember who was served last so a tie goes to the other requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (accept && |gnt) last <= gnt[1];
endmodule

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: arbitrates two requesters into PRE/ACT/RD/WR commands with open-row tracking
module sdram_cmd_sched
  import sdram_pkg::*;
#(
  parameter int ROW_WD = 13,
  parameter int COL_WD = 10,
  parameter int LEN_WD = 12,
  parameter int IDLE_CLOSE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wr,
  input  logic [2*ROW_WD-1:0] req_row,
  input  logic [2*COL_WD-1:0] req_col,
  input  logic [3:0]          req_ba,
  input  logic [2*LEN_WD-1:0] req_len,
  output logic [1:0]          done,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [3:0]          cmd,
  output logic [ROW_WD-1:0]   row_addr,
  output logic [COL_WD-1:0]   col_addr,
  output logic [1:0]          cmd_ba,
  output logic [LEN_WD-1:0]   r_cmd_len,
  output logic [LEN_WD-1:0]   w_cmd_len
);
  localparam int CNT_WD = $clog2(IDLE_CLOSE);
  state_t st, nxt;
  logic [1:0] gnt;
  logic gsel, grant, fire, hit, g_q, wr_q, pend, open_q;
  logic [ROW_WD-1:0] g_row, row_q, open_row;
  logic [COL_WD-1:0] col_q;
  logic [LEN_WD-1:0] len_q;
  logic [1:0] g_ba, ba_q, open_ba;
  logic [CNT_WD-1:0] idle_cnt;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req(req_valid), .accept(grant), .gnt(gnt));
  assign gsel = gnt[1];
  assign grant = (st == S_IDLE) && |req_valid;
  assign fire = cmd_valid && cmd_ready;
  assign g_row = req_row[gsel*ROW_WD +: ROW_WD];
  assign g_ba = req_ba[gsel*2 +: 2];
  assign hit = open_q && open_ba == g_ba && open_row == g_row;
  assign req_ready = (rst_n && st == S_IDLE) ? gnt : 2'b00;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_IDLE;
    else st <= nxt;
  // next state and command outputs; outputs are held by the latched request until fire
  always_comb begin
    nxt = st;
    cmd_valid = 1'b0;
    cmd = '0;
    row_addr = '0;
    col_addr = '0;
    cmd_ba = '0;
    r_cmd_len = '0;
    w_cmd_len = '0;
    case (st)
      S_IDLE: begin
        if (|req_valid) nxt = !open_q ? S_ACT : (hit ? S_RW : S_PRE);
        else if (open_q && idle_cnt == CNT_WD'(IDLE_CLOSE - 1)) nxt = S_PRE;
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd = CMD_PRE;
        cmd_ba = open_ba;
        if (fire) nxt = pend ? S_ACT : S_IDLE;
      end
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd = CMD_ACT;
        row_addr = row_q;
        cmd_ba = ba_q;
        if (fire) nxt = S_RW;
      end
      default: begin
        cmd_valid = 1'b1;
        cmd = wr_q ? CMD_WR : CMD_RD;
        col_addr = col_q;
        cmd_ba = ba_q;
        r_cmd_len = wr_q ? '0 : len_q;
        w_cmd_len = wr_q ? len_q : '0;
        if (fire) nxt = S_IDLE;
      end
    endcase
  end
  // request latch, open-row bookkeeping, idle timer and completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g_q <= 1'b0;
      wr_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      ba_q <= '0;
      len_q <= '0;
      pend <= 1'b0;
      open_q <= 1'b0;
      open_ba <= '0;
      open_row <= '0;
      idle_cnt <= '0;
      done <= '0;
    end else begin
      if (grant) begin
        g_q <= gsel;
        wr_q <= req_wr[gsel];
        row_q <= g_row;
        col_q <= req_col[gsel*COL_WD +: COL_WD];
        ba_q <= g_ba;
        len_q <= req_len[gsel*LEN_WD +: LEN_WD];
        pend <= 1'b1;
      end
      if (st == S_ACT && fire) begin
        open_q <= 1'b1;
        open_ba <= ba_q;
        open_row <= row_q;
      end
      if (st == S_PRE && fire) open_q <= 1'b0;
      if (st == S_RW && fire) pend <= 1'b0;
      idle_cnt <= (st == S_IDLE && nxt == S_IDLE && open_q) ? idle_cnt + 1'b1 : '0;
      done <= (st == S_RW && fire) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule
